// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame width and the
// {CPol,CPha} mode encoding that the master also uses.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  // One-hot FSM states
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_LOAD  = 4'b0010;
  localparam logic [3:0] ST_SHIFT = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  // Data is sampled on the rising SCK edge exactly when CPol equals CPha.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return mode[1] == mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a third flop whose
// comparison with the synchronised level flags any edge (rise/fall by level).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic lvl,
  output logic chg
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lvl = sync_q[1];
  assign chg = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI responder, all four modes, MSB first, oversampled on Clk (Clk >= 8x SCK).
// Optional SPI_SLAVE_OVERRUN_EN adds RxAck/Overrun receive-overrun tracking.
module spi_slave
  import spi_pkg::*;
#(
  parameter int               DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] TX_IDLE = {DATA_W{1'b1}}
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CPol,
  input  logic              CPha,
  input  logic              SCK,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MisoOe,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxWrite,
  output logic              TxReady,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic              Busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              RxAck,
  output logic              Overrun
`endif
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sck_lvl, sck_chg, ss_lvl, ss_chg;
  logic [1:0] mosi_s_q, mosi_s_d;
  spi_mode_e mode;
  logic sample_edge, shift_edge, ss_fall, ss_rise;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(Clk), .rst(Rst), .d_in(SCK), .lvl(sck_lvl), .chg(sck_chg)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk(Clk), .rst(Rst), .d_in(SS_n), .lvl(ss_lvl), .chg(ss_chg)
  );

  assign mode        = spi_mode_e'({CPol, CPha});
  assign sample_edge = sck_chg & (sck_lvl == sample_on_rise(mode));
  assign shift_edge  = sck_chg & (sck_lvl != sample_on_rise(mode));
  assign ss_fall     = ss_chg & ~ss_lvl;
  assign ss_rise     = ss_chg & ss_lvl;

  logic [3:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic              tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d, miso_q, miso_d;
  logic [DATA_W-1:0] tx_word;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic              rx_pend_q, rx_pend_d, overrun_q, overrun_d;
`endif

  assign tx_word = tx_ready_q ? TX_IDLE : hold_q;

  always_comb begin
    mosi_s_d   = {mosi_s_q[0], MOSI};
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_pend_d  = rx_pend_q & ~RxAck;
    overrun_d  = overrun_q & ~RxAck;
`endif

    if (TxWrite && tx_ready_q) begin
      hold_d     = TxData;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end else begin
          tx_sh_d    = tx_word;
          miso_d     = tx_word[DATA_W-1];
          cnt_d      = '0;
          hold_d     = TxWrite ? TxData : hold_q;
          tx_ready_d = ~TxWrite;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end else if (sample_edge) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s_q[1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = ST_DONE;
        end else if (shift_edge && cnt_q != '0) begin
          // Shift edges before the first sample (CPha=1 opener, or the CPha=0
          // trailing edge left over from a previous back-to-back frame) hold the MSB.
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          miso_d  = tx_sh_q[DATA_W-2];
        end
      end
      ST_DONE: begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
        if (rx_pend_d) overrun_d = 1'b1;
        rx_pend_d = 1'b1;
`endif
        state_d = ss_lvl ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mosi_s_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_pend_q  <= 1'b0;
      overrun_q  <= 1'b0;
`endif
    end else begin
      mosi_s_q   <= mosi_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_pend_q  <= rx_pend_d;
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign MISO    = miso_q;
  assign MisoOe  = (state_q != ST_IDLE);
  assign Busy    = (state_q != ST_IDLE);
  assign TxReady = tx_ready_q;
  assign RxData  = rx_data_q;
  assign RxValid = rx_valid_q;
`ifdef SPI_SLAVE_OVERRUN_EN
  assign Overrun = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bus-level SPI master driving directed frames; received
// words go through a scoreboard queue checked whenever RxValid pulses.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HP = 80;  // SCK half period = 8 Clk cycles

  logic       Clk = 1'b0;
  logic       Rst, CPol, CPha, SCK, SS_n, MOSI;
  logic       MISO, MisoOe, TxWrite, TxReady, RxValid, Busy;
  logic [7:0] TxData, RxData;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       RxAck, Overrun;
`endif

  int         n_pass = 0;
  int         n_total = 0;
  int         unstable = 0;
  time        last_miso_t = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [7:0] got, got2;

  always #5 Clk = ~Clk;

  spi_slave dut (
    .Clk(Clk), .Rst(Rst), .CPol(CPol), .CPha(CPha), .SCK(SCK), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO), .MisoOe(MisoOe), .TxData(TxData), .TxWrite(TxWrite),
    .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .Busy(Busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .RxAck(RxAck), .Overrun(Overrun)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every RxValid pulse pops one expected word.
  always @(negedge Clk) begin
    if (Rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) check("rxvalid_one_cycle", RxValid, 0);
      if (RxValid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected: RxValid with RxData=%0h, no word expected", RxData);
        end else begin
          check("rx_data", RxData, exp_q.pop_front());
        end
      end
      prev_valid = RxValid;
    end
  end

  // MISO must have settled well before each master sample edge.
  always @(MISO) last_miso_t = $time;
  always @(SCK) begin
    if (!SS_n && ((SCK != CPol) ^ CPha) && ($time - last_miso_t < 20)) unstable++;
  end

  task automatic tx_write(input logic [7:0] d);
    @(negedge Clk); TxData = d; TxWrite = 1'b1;
    @(negedge Clk); TxWrite = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    CPol = pol; CPha = pha; SCK = pol;
    repeat (4) @(negedge Clk);
  endtask

  task automatic do_ack();
`ifdef SPI_SLAVE_OVERRUN_EN
    @(negedge Clk); RxAck = 1'b1;
    @(negedge Clk); RxAck = 1'b0;
    @(negedge Clk);
    check("overrun_after_ack", Overrun, 0);
`else
    @(negedge Clk);
`endif
  endtask

  task automatic run_bits(input logic [7:0] w, input int nbits, output logic [7:0] g);
    g = '0;
    if (!CPha) MOSI = w[7];
    for (int i = 0; i < nbits; i++) begin
      #HP; SCK = ~CPol;
      if (CPha) MOSI = w[7-i]; else g = {g[6:0], MISO};
      #HP; SCK = CPol;
      if (CPha) g = {g[6:0], MISO}; else if (i < 7) MOSI = w[6-i];
    end
  endtask

  task automatic frame_open();
    SS_n = 1'b0;
    #HP;
    check("busy_in_frame", Busy, 1);
    check("misooe_in_frame", MisoOe, 1);
    check("txready_after_load", TxReady, 1);
  endtask

  task automatic frame_close(input bit ack);
    #HP; SS_n = 1'b1;
    #(2*HP);
    if (ack) do_ack();
  endtask

  task automatic xfer(input logic [7:0] w, input bit ack, output logic [7:0] g);
    frame_open();
    run_bits(w, 8, g);
    frame_close(ack);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; CPol = 1'b0; CPha = 1'b0; SCK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    TxData = '0; TxWrite = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    RxAck = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check("rst_miso", MISO, 0);
    check("rst_misooe", MisoOe, 0);
    check("rst_txready", TxReady, 1);
    check("rst_rxdata", RxData, 0);
    check("rst_rxvalid", RxValid, 0);
    check("rst_busy", Busy, 0);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    check("idle_busy", Busy, 0);

    // Mode 0, second write while full must be ignored
    set_mode(1'b0, 1'b0);
    tx_write(8'hA5);
    check("txready_after_write", TxReady, 0);
    tx_write(8'h77);
    exp_q.push_back(8'h3C);
    xfer(8'h3C, 1'b1, got);
    check("mode0_miso", got, 8'hA5);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_write(8'h5A);
      exp_q.push_back(8'hC3);
      xfer(8'hC3, 1'b1, got);
      check($sformatf("mode%0d_miso", m), got, 8'h5A);
    end
    check("miso_stable_at_sample", unstable, 0);

    // No write: idle word shifted out
    set_mode(1'b0, 1'b0);
    exp_q.push_back(8'h00);
    xfer(8'h00, 1'b1, got);
    check("idle_word_miso", got, 8'hFF);

    // Abort after 4 SCK cycles, then a clean frame
    SS_n = 1'b0;
    #HP;
    run_bits(8'hF0, 4, got);
    SS_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    check("abort_misooe", MisoOe, 0);
    check("abort_busy", Busy, 0);
    #(2*HP);
    exp_q.push_back(8'h81);
    xfer(8'h81, 1'b1, got);
    check("after_abort_miso", got, 8'hFF);

    // Back-to-back frames with SS_n held low
    tx_write(8'h66);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    frame_open();
    run_bits(8'h11, 8, got);
    run_bits(8'h22, 8, got2);
    frame_close(1'b1);
    check("b2b_first_miso", got, 8'h66);
    check("b2b_second_miso", got2, 8'hFF);

`ifdef SPI_SLAVE_OVERRUN_EN
    exp_q.push_back(8'h31);
    xfer(8'h31, 1'b0, got);
    check("overrun_single", Overrun, 0);
    exp_q.push_back(8'h32);
    xfer(8'h32, 1'b0, got);
    check("overrun_set", Overrun, 1);
    check("overrun_rxdata", RxData, 8'h32);
    do_ack();
`endif

    repeat (10) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
